// File: rtl/tamagotchi_stat_sched.sv
// Pet stat scheduler: prescaled decay timers plus sticky user requests, arbitrated
// by a small FSM so at most one stat level changes per clock.
module tamagotchi_stat_sched #(
  parameter int unsigned DIVISOR     = 2500000,
  parameter int unsigned T_SALUD     = 1200,
  parameter int unsigned T_HAMBRE    = 700,
  parameter int unsigned T_DIVERSION = 500,
  parameter int unsigned T_ENERGIA   = 10,
  parameter int unsigned LVL_MAX     = 10,
  parameter int unsigned LVL_INIT    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ledsign,
  input  logic       test_mode,
  input  logic       req_feed,
  input  logic       req_play,
  input  logic       req_heal,
  output logic [3:0] nivel_salud,
  output logic [3:0] nivel_energia,
  output logic [3:0] nivel_hambre,
  output logic [3:0] nivel_diversion,
  output logic [2:0] grant,
  output logic [3:0] decay_strobe,
  output logic       tick,
  output logic       busy
);

  localparam int unsigned PW    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned T_M1  = (T_SALUD > T_HAMBRE) ? T_SALUD : T_HAMBRE;
  localparam int unsigned T_M2  = (T_DIVERSION > T_ENERGIA) ? T_DIVERSION : T_ENERGIA;
  localparam int unsigned T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int unsigned TW    = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;
  // Timer index matches decay_strobe bit: salud, energia, hambre, diversion
  localparam int unsigned T_THR [4] = '{T_SALUD, T_ENERGIA, T_HAMBRE, T_DIVERSION};

  typedef enum logic [1:0] {S_IDLE, S_DECAY, S_SERVE} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [TW-1:0]   r_tmr [4];
  logic [3:0]      r_dpend;
  logic [2:0]      r_upend;
  logic [1:0]      r_rr_last;

  logic            w_wrap;
  logic            w_adv;
  logic [3:0]      w_hit;
  logic [3:0]      w_dsel;
  logic [2:0]      w_gsel;
  logic [1:0]      w_gidx;
  logic [3:0]      w_dpend_nxt;
  logic [2:0]      w_upend_nxt;

  function automatic logic [3:0] sat_add(input logic [3:0] lvl, input logic [2:0] amt);
    logic [4:0] s;
    s = {1'b0, lvl} + {2'b00, amt};
    return (s > 5'(LVL_MAX)) ? 4'(LVL_MAX) : s[3:0];
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] lvl);
    logic [4:0] s;
    s = {1'b0, lvl} - 5'd1;
    if (s[4]) return 4'd0;
    return (s > 5'(LVL_MAX)) ? 4'(LVL_MAX) : s[3:0];
  endfunction

  // Round-robin: first pending bit strictly after the last granted one
  function automatic logic [2:0] rr_pick(input logic [2:0] pend, input logic [1:0] last);
    logic [2:0] g;
    logic [1:0] idx;
    g = '0;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % 3);
      if (pend[idx]) g = 3'(1) << idx;
    end
    return g;
  endfunction

  always_comb begin
    w_wrap = (r_presc == PW'(DIVISOR - 1));
    w_adv  = w_wrap && !test_mode;
    for (int i = 0; i < 4; i++) begin
      w_hit[i] = w_adv && (r_tmr[i] == TW'(T_THR[i]));
    end
    w_dsel = '0;
    if (r_state == S_DECAY) w_dsel = r_dpend & (~r_dpend + 4'd1);
    w_gsel = '0;
    if (r_state == S_SERVE) w_gsel = rr_pick(r_upend, r_rr_last);
    w_gidx = r_rr_last;
    if (w_gsel[0])      w_gidx = 2'd0;
    else if (w_gsel[1]) w_gidx = 2'd1;
    else if (w_gsel[2]) w_gidx = 2'd2;
    w_dpend_nxt = (r_dpend & ~w_dsel) | w_hit;
    w_upend_nxt = (r_upend & ~w_gsel) | {req_heal, req_play, req_feed};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_presc         <= '0;
      for (int i = 0; i < 4; i++) r_tmr[i] <= '0;
      r_dpend         <= '0;
      r_upend         <= '0;
      r_rr_last       <= 2'd2;
      nivel_salud     <= 4'(LVL_INIT);
      nivel_energia   <= 4'(LVL_INIT);
      nivel_hambre    <= 4'(LVL_INIT);
      nivel_diversion <= 4'(LVL_INIT);
      grant           <= '0;
      decay_strobe    <= '0;
      tick            <= 1'b0;
      busy            <= 1'b0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + PW'(1);
      tick    <= w_wrap;
      for (int i = 0; i < 4; i++) begin
        if (w_adv) r_tmr[i] <= w_hit[i] ? '0 : r_tmr[i] + TW'(1);
      end
      r_dpend      <= w_dpend_nxt;
      r_upend      <= w_upend_nxt;
      busy         <= (|w_dpend_nxt) || (|w_upend_nxt);
      grant        <= w_gsel;
      decay_strobe <= w_dsel;

      // DECAY and SERVE are exclusive states, so only one level moves per cycle
      if (w_dsel[0]) nivel_salud     <= sat_dec(nivel_salud);
      if (w_dsel[1]) nivel_energia   <= ledsign ? sat_add(nivel_energia, 3'd1)
                                                : sat_dec(nivel_energia);
      if (w_dsel[2]) nivel_hambre    <= sat_dec(nivel_hambre);
      if (w_dsel[3]) nivel_diversion <= sat_dec(nivel_diversion);
      if (w_gsel[0]) nivel_hambre    <= sat_add(nivel_hambre, 3'd2);
      if (w_gsel[1]) nivel_diversion <= sat_add(nivel_diversion, 3'd2);
      if (w_gsel[2]) nivel_salud     <= sat_add(nivel_salud, 3'd3);
      if (|w_gsel)   r_rr_last       <= w_gidx;

      case (r_state)
        S_IDLE: begin
          if (|r_dpend)      r_state <= S_DECAY;
          else if (|r_upend) r_state <= S_SERVE;
        end
        S_DECAY: begin
          if ((r_dpend & ~w_dsel) == 4'd0) r_state <= S_IDLE;
        end
        S_SERVE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tamagotchi_stat_sched.sv
// Directed bench for tamagotchi_stat_sched: expected services are queued as stimulus
// is applied and matched in order against grant/decay_strobe pulses.
module tb_tamagotchi_stat_sched;

  localparam int DIV   = 4;
  localparam int TS    = 5;
  localparam int TE    = 2;
  localparam int TH    = 3;
  localparam int TD    = 3;
  localparam int LMAX  = 10;
  localparam int LINIT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ledsign;
  logic       test_mode;
  logic       req_feed, req_play, req_heal;
  logic [3:0] nivel_salud, nivel_energia, nivel_hambre, nivel_diversion;
  logic [2:0] grant;
  logic [3:0] decay_strobe;
  logic       tick, busy;

  tamagotchi_stat_sched #(
    .DIVISOR(DIV), .T_SALUD(TS), .T_HAMBRE(TH), .T_DIVERSION(TD),
    .T_ENERGIA(TE), .LVL_MAX(LMAX), .LVL_INIT(LINIT)
  ) dut (
    .clk(clk), .rst(rst), .ledsign(ledsign), .test_mode(test_mode),
    .req_feed(req_feed), .req_play(req_play), .req_heal(req_heal),
    .nivel_salud(nivel_salud), .nivel_energia(nivel_energia),
    .nivel_hambre(nivel_hambre), .nivel_diversion(nivel_diversion),
    .grant(grant), .decay_strobe(decay_strobe), .tick(tick), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] g;
    logic [3:0] d;
    int         lvl;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_events = 0;
  int   m_s, m_e, m_h, m_f;
  int   n_adv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > LMAX) return LMAX;
    return v;
  endfunction

  function automatic void push(input string tag, input logic [2:0] g, input logic [3:0] d,
                               input int lvl);
    exp_t e;
    e.tag = tag; e.g = g; e.d = d; e.lvl = lvl;
    q.push_back(e);
  endfunction

  // Timers of period T+1 ticks since reset; same-tick services go out in salud..diversion order
  function automatic void model_tick(input int n);
    if (n % (TS + 1) == 0) begin m_s = sat(m_s - 1); push("dec_salud", 3'b000, 4'b0001, m_s); end
    if (n % (TE + 1) == 0) begin
      m_e = sat(ledsign ? m_e + 1 : m_e - 1);
      push("dec_energia", 3'b000, 4'b0010, m_e);
    end
    if (n % (TH + 1) == 0) begin m_h = sat(m_h - 1); push("dec_hambre", 3'b000, 4'b0100, m_h); end
    if (n % (TD + 1) == 0) begin m_f = sat(m_f - 1); push("dec_diversion", 3'b000, 4'b1000, m_f); end
  endfunction

  function automatic logic [3:0] lvl_of(input logic [2:0] g, input logic [3:0] d);
    if (d[0] || g[2]) return nivel_salud;
    if (d[1])         return nivel_energia;
    if (d[2] || g[0]) return nivel_hambre;
    return nivel_diversion;
  endfunction

  // Service monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && ((|grant) || (|decay_strobe))) begin
      n_events++;
      check("no_overlap", 32'((|grant) && (|decay_strobe)), 32'd0);
      if (q.size() == 0) begin
        check("unexpected_event", {25'b0, grant, decay_strobe}, 32'd0);
      end else begin
        e_mon = q.pop_front();
        check({e_mon.tag, "_code"}, {25'b0, grant, decay_strobe}, {25'b0, e_mon.g, e_mon.d});
        check({e_mon.tag, "_level"}, 32'(lvl_of(e_mon.g, e_mon.d)), 32'(e_mon.lvl));
      end
    end
  end

  task automatic wait_tick();
    int g = 0;
    do begin @(negedge clk); g++; end while (tick !== 1'b1 && g < 50);
    if (tick !== 1'b1) check("tick_sync", 32'(tick), 32'd1);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (q.size() != 0 && g < 300) begin @(negedge clk); g++; end
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic pulse(input logic f, input logic p, input logic h);
    @(posedge clk); #1;
    req_feed = f; req_play = p; req_heal = h;
    @(posedge clk); #1;
    req_feed = 1'b0; req_play = 1'b0; req_heal = 1'b0;
  endtask

  task automatic run_ticks(input int k);
    int seen = 0;
    int g = 0;
    for (int t = 1; t <= k; t++) model_tick(n_adv + t);
    wait_tick();
    test_mode = 1'b0;
    while (seen < k && g < k * DIV * 2 + 20) begin
      @(negedge clk); g++;
      if (tick === 1'b1) seen++;
    end
    test_mode = 1'b1;
    check("ticks_seen", 32'(seen), 32'(k));
    n_adv += k;
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] glog;
    logic [23:0] glog_exp;
    int seen, cyc, ev0;
    rst = 1'b1; test_mode = 1'b1; ledsign = 1'b0;
    req_feed = 1'b0; req_play = 1'b0; req_heal = 1'b0;
    m_s = LINIT; m_e = LINIT; m_h = LINIT; m_f = LINIT; n_adv = 0;
    glog = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_salud", 32'(nivel_salud), 32'(LINIT));
    check("rst_energia", 32'(nivel_energia), 32'(LINIT));
    check("rst_hambre", 32'(nivel_hambre), 32'(LINIT));
    check("rst_diversion", 32'(nivel_diversion), 32'(LINIT));
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_decay", 32'(decay_strobe), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Awake pet: three ticks give exactly one energy drain
    run_ticks(3);
    check("energia_3ticks", 32'(nivel_energia), 32'd7);

    // Single feed: latch, IDLE->SERVE, then grant with level update
    m_h = sat(m_h + 2); push("feed_lat", 3'b001, 4'b0000, m_h);
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_c1_grant", 32'(grant), 32'd0);
    check("lat_c1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("lat_c2_grant", 32'(grant), 32'd0);
    @(negedge clk);
    check("lat_c3_grant", 32'(grant), 32'b001);
    check("lat_c3_hambre", 32'(nivel_hambre), 32'd10);
    check("lat_c3_busy", 32'(busy), 32'd0);
    wait_drain();
    for (int i = 0; i < 4; i++) begin
      m_h = sat(m_h + 2); push("feed_sat", 3'b001, 4'b0000, m_h);
      pulse(1'b1, 1'b0, 1'b0);
      wait_drain();
    end
    check("hambre_ceiling", 32'(nivel_hambre), 32'd10);

    // Strobe held through its own grant edge yields exactly one extra service
    m_h = sat(m_h + 2); push("feed_hold1", 3'b001, 4'b0000, m_h);
    m_h = sat(m_h + 2); push("feed_hold2", 3'b001, 4'b0000, m_h);
    @(posedge clk); #1 req_feed = 1'b1;
    repeat (3) @(posedge clk);
    #1 req_feed = 1'b0;
    wait_drain();

    // Reset while in SERVE discards the pending play grant
    pulse(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("serve_busy", 32'(busy), 32'd1);
    check("serve_grant_pre", 32'(grant), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_salud", 32'(nivel_salud), 32'(LINIT));
    check("midrst_energia", 32'(nivel_energia), 32'(LINIT));
    check("midrst_hambre", 32'(nivel_hambre), 32'(LINIT));
    check("midrst_diversion", 32'(nivel_diversion), 32'(LINIT));
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    m_s = LINIT; m_e = LINIT; m_h = LINIT; m_f = LINIT; n_adv = 0;

    // All three requests at once: feed first, IDLE cycle between grants
    m_h = sat(m_h + 2); push("rr_feed", 3'b001, 4'b0000, m_h);
    m_f = sat(m_f + 2); push("rr_play", 3'b010, 4'b0000, m_f);
    m_s = sat(m_s + 3); push("rr_heal", 3'b100, 4'b0000, m_s);
    pulse(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      glog = {glog[20:0], grant};
    end
    glog_exp = {3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
    check("rr_pattern", 32'(glog), 32'(glog_exp));
    wait_drain();
    check("rr_salud", 32'(nivel_salud), 32'd10);
    check("rr_diversion", 32'(nivel_diversion), 32'd10);

    // Heal latched on the same edge hunger/fun flags rise: decays go first
    for (int t = 1; t <= 4; t++) model_tick(t);
    m_s = sat(m_s + 3); push("heal_after_decay", 3'b100, 4'b0000, m_s);
    wait_tick();
    test_mode = 1'b0;
    seen = 0; cyc = 0;
    while (seen < 3 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (tick === 1'b1) seen++;
    end
    check("pre_heal_ticks", 32'(seen), 32'd3);
    repeat (3) @(posedge clk);
    #1 req_heal = 1'b1;
    @(posedge clk); #1 req_heal = 1'b0;
    @(negedge clk);
    check("tick4_align", 32'(tick), 32'd1);
    test_mode = 1'b1;
    n_adv = 4;
    wait_drain();

    // Resting pet: energy recovers to the ceiling, salud decays to and holds at 0
    ledsign = 1'b1;
    run_ticks(62);
    check("salud_floor", 32'(nivel_salud), 32'd0);
    check("energia_ceiling", 32'(nivel_energia), 32'd10);
    check("hambre_floor", 32'(nivel_hambre), 32'd0);

    // Frozen timers: ticks keep coming, no decay service
    ev0 = n_events;
    wait_tick();
    seen = 0; cyc = 0;
    while (seen < 20 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (tick === 1'b1) seen++;
    end
    check("freeze_tick_period", 32'(cyc), 32'd80);
    check("freeze_no_events", 32'(n_events - ev0), 32'd0);
    run_ticks(6);
    check("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
